// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan capture block:
// glyph patterns (abcdefg order) and the capture FSM encoding.
package seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational seven-segment glyph to hex decoder.
// Unknown patterns (blank included) give code 0 with match low.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       match
);

    // Table lookup of the 16 hex glyphs
    always_comb begin
        code  = 4'h0;
        match = 1'b1;
        unique case (pattern)
            GLYPH_0: code = 4'h0;
            GLYPH_1: code = 4'h1;
            GLYPH_2: code = 4'h2;
            GLYPH_3: code = 4'h3;
            GLYPH_4: code = 4'h4;
            GLYPH_5: code = 4'h5;
            GLYPH_6: code = 4'h6;
            GLYPH_7: code = 4'h7;
            GLYPH_8: code = 4'h8;
            GLYPH_9: code = 4'h9;
            GLYPH_A: code = 4'hA;
            GLYPH_B: code = 4'hB;
            GLYPH_C: code = 4'hC;
            GLYPH_D: code = 4'hD;
            GLYPH_E: code = 4'hE;
            GLYPH_F: code = 4'hF;
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs per-digit hex codes from a multiplexed 7-seg scan bus.
// Optional watchdog: define SEG_TIMEOUT_EN to enable the stall counter.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int STABLE_CYC = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [DIGITS-1:0]     SEG_COM,
    input  logic [7:0]            SEG_DATA,
    output logic [4*DIGITS-1:0]   digit_code,
    output logic [DIGITS-1:0]     digit_dp,
    output logic                  frame_valid,
    output logic                  seg_err,
    output logic                  com_err,
    output logic                  stall
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [4:0]            cnt_inc;
    logic [DIGITS-1:0]     prev_com_q;
    logic [7:0]            prev_data_q;
    logic [DIGITS-1:0]     cap_com_q, cap_com_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]     sdp_q, sdp_d;
    logic [DIGITS-1:0]     seen_q, seen_d, seen_w;
    logic [4*DIGITS-1:0]   code_q, code_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic                  fv_q, fv_d;
    logic                  serr_q, serr_d;
    logic                  cerr_q, cerr_d;
    logic                  cap_en;
    logic                  to_fire;

    logic [DIGITS-1:0]     zeros;
    logic                  multi;
    logic                  com_ok;
    logic                  stable;
    logic [IW-1:0]         idx;
    logic [3:0]            dec_code;
    logic                  dec_match;

    assign zeros   = ~SEG_COM;
    assign multi   = |(zeros & (zeros - 1'b1));
    assign com_ok  = (|zeros) && !multi;
    assign stable  = ({SEG_COM, SEG_DATA} == {prev_com_q, prev_data_q});
    assign cnt_inc = {1'b0, cnt_q} + 5'd1;

    // Capture uses the registered bus: it is the value proven stable
    seg_glyph_decode u_dec (
        .pattern (prev_data_q[7:1]),
        .code    (dec_code),
        .match   (dec_match)
    );

    // Index of the low select bit in the settled bus value
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!prev_com_q[i]) idx = IW'(i);
        end
    end

    // Capture FSM next-state and settle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (com_ok) begin
                    state_d = SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            SETTLE: begin
                if (!stable) begin
                    state_d = com_ok ? SETTLE : IDLE;
                    cnt_d   = 4'd1;
                end else if (cnt_inc >= 5'(STABLE_CYC)) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_inc[3:0];
                end
            end
            CAPTURE: begin
                cap_en  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (SEG_COM != cap_com_q) begin
                    state_d = com_ok ? SETTLE : IDLE;
                    cnt_d   = 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow update, frame publish and sticky error flags
    always_comb begin
        shadow_d  = shadow_q;
        sdp_d     = sdp_q;
        cap_com_d = cap_com_q;
        serr_d    = serr_q;
        cerr_d    = cerr_q | multi;
        code_d    = code_q;
        dp_d      = dp_q;
        fv_d      = 1'b0;
        seen_w    = to_fire ? '0 : seen_q;
        if (cap_en) begin
            shadow_d[4*idx +: 4] = dec_code;
            sdp_d[idx]           = prev_data_q[0];
            seen_w[idx]          = 1'b1;
            cap_com_d            = prev_com_q;
            if (!dec_match) serr_d = 1'b1;
        end
        seen_d = seen_w;
        if (&seen_w) begin
            code_d = shadow_d;
            dp_d   = sdp_d;
            fv_d   = 1'b1;
            seen_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_com_q  <= '1;
            prev_data_q <= '0;
            cap_com_q   <= '1;
            shadow_q    <= '0;
            sdp_q       <= '0;
            seen_q      <= '0;
            code_q      <= '0;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            serr_q      <= 1'b0;
            cerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_com_q  <= SEG_COM;
            prev_data_q <= SEG_DATA;
            cap_com_q   <= cap_com_d;
            shadow_q    <= shadow_d;
            sdp_q       <= sdp_d;
            seen_q      <= seen_d;
            code_q      <= code_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            serr_q      <= serr_d;
            cerr_q      <= cerr_d;
        end
    end

`ifdef SEG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_q, to_d;
    logic          stall_q, stall_d;

    assign to_fire = (to_q == TW'(TIMEOUT - 1));

    // Watchdog: restarts on publish, saturates at TIMEOUT
    always_comb begin
        to_d    = to_q;
        stall_d = stall_q;
        if (fv_d) begin
            to_d    = '0;
            stall_d = 1'b0;
        end else begin
            if (to_fire) stall_d = 1'b1;
            if (to_q != TW'(TIMEOUT)) to_d = to_q + 1'b1;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            to_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            to_q    <= to_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign to_fire        = 1'b0;
    assign stall          = 1'b0;
`endif

    assign digit_code  = code_q;
    assign digit_dp    = dp_q;
    assign frame_valid = fv_q;
    assign seg_err     = serr_q;
    assign com_err     = cerr_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a frame scoreboard.
// Define SEG_TIMEOUT_EN to include the watchdog sequence.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  SEG_COM;
    logic [7:0]  SEG_DATA;
    logic [31:0] digit_code;
    logic [7:0]  digit_dp;
    logic        frame_valid;
    logic        seg_err;
    logic        com_err;
    logic        stall;

    typedef struct packed {
        logic [31:0] code;
        logic [7:0]  dp;
    } frame_t;

    frame_t     sb[$];
    int         nvec    = 0;
    int         nerr    = 0;
    int         nframes = 0;
    logic [6:0] gl [16];

    always #5 clk = ~clk;

    seg_scan_capture #(
        .DIGITS     (8),
        .STABLE_CYC (3),
        .TIMEOUT    (4096)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .SEG_COM     (SEG_COM),
        .SEG_DATA    (SEG_DATA),
        .digit_code  (digit_code),
        .digit_dp    (digit_dp),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .com_err     (com_err),
        .stall       (stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] g,
                        input logic dp, input int n);
        SEG_COM  = ~(8'd1 << d);
        SEG_DATA = {g, dp};
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        SEG_COM  = 8'hFF;
        SEG_DATA = 8'h00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic full_scan();
        for (int i = 0; i < 8; i++) show(i, gl[i], 1'b0, 10);
        blank(5);
    endtask

    // Frame monitor: every publish must match the oldest expected frame
    always @(negedge clk) begin
        frame_t e;
        if (frame_valid) begin
            nframes++;
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("frame_code", 64'(digit_code), 64'(e.code));
                chk("frame_dp", 64'(digit_dp), 64'(e.dp));
            end
        end
    end

    initial begin
        gl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        Reset    = 1'b1;
        SEG_COM  = 8'hFF;
        SEG_DATA = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_code", 64'(digit_code), 64'd0);
        chk("rst_dp", 64'(digit_dp), 64'd0);
        chk("rst_fv", 64'(frame_valid), 64'd0);
        chk("rst_seg_err", 64'(seg_err), 64'd0);
        chk("rst_com_err", 64'(com_err), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;

        blank(20);
        chk("blank_frames", 64'(nframes), 64'd0);
        chk("blank_code", 64'(digit_code), 64'd0);

        sb.push_back('{32'h76543210, 8'h00});
        full_scan();
        chk("scan1_frames", 64'(nframes), 64'd1);
        chk("scan1_seg_err", 64'(seg_err), 64'd0);

        sb.push_back('{32'h7654A210, 8'h08});
        for (int i = 0; i < 8; i++) begin
            if (i == 3) show(i, gl[10], 1'b1, 10);
            else        show(i, gl[i], 1'b0, 10);
        end
        blank(5);
        chk("scan2_frames", 64'(nframes), 64'd2);

        for (int i = 0; i < 8; i++) show(i, gl[15], 1'b0, 2);
        blank(5);
        chk("short_frames", 64'(nframes), 64'd2);
        chk("short_code", 64'(digit_code), 64'h7654A210);
        for (int i = 0; i < 7; i++) show(i, gl[i+8], 1'b0, 10);
        blank(5);
        chk("partial_frames", 64'(nframes), 64'd2);
        sb.push_back('{32'hFEDCBA98, 8'h80});
        show(7, gl[15], 1'b1, 10);
        blank(5);
        chk("scan3_frames", 64'(nframes), 64'd3);

        SEG_COM  = 8'hFC;
        SEG_DATA = {gl[1], 1'b0};
        repeat (5) @(posedge clk);
        #1;
        blank(5);
        chk("multi_com_err", 64'(com_err), 64'd1);
        chk("multi_seg_err", 64'(seg_err), 64'd0);
        chk("multi_frames", 64'(nframes), 64'd3);

        sb.push_back('{32'h76043C10, 8'h00});
        show(0, gl[0], 1'b0, 10);
        show(1, gl[8], 1'b0, 2);
        show(1, gl[1], 1'b0, 8);
        show(2, gl[9], 1'b0, 10);
        show(3, gl[3], 1'b0, 10);
        show(4, gl[4], 1'b0, 6);
        show(4, gl[14], 1'b0, 4);
        show(5, 7'b0000001, 1'b0, 10);
        show(6, gl[6], 1'b0, 10);
        show(2, gl[12], 1'b0, 10);
        show(7, gl[7], 1'b0, 10);
        blank(5);
        chk("scan4_frames", 64'(nframes), 64'd4);
        chk("bad_glyph_seg_err", 64'(seg_err), 64'd1);

        for (int i = 0; i < 4; i++) show(i, gl[i], 1'b0, 10);
        Reset = 1'b1;
        @(negedge clk);
        chk("midrst_code", 64'(digit_code), 64'd0);
        chk("midrst_dp", 64'(digit_dp), 64'd0);
        chk("midrst_seg_err", 64'(seg_err), 64'd0);
        chk("midrst_com_err", 64'(com_err), 64'd0);
        blank(2);
        Reset = 1'b0;
        blank(3);
        for (int i = 4; i < 8; i++) show(i, gl[i], 1'b0, 10);
        blank(5);
        chk("midrst_frames", 64'(nframes), 64'd4);
        sb.push_back('{32'h76543210, 8'h00});
        full_scan();
        chk("scan5_frames", 64'(nframes), 64'd5);

`ifdef SEG_TIMEOUT_EN
        for (int i = 0; i < 4; i++) show(i, gl[i], 1'b0, 10);
        blank(4100);
        chk("to_stall_set", 64'(stall), 64'd1);
        for (int i = 4; i < 8; i++) show(i, gl[i], 1'b0, 10);
        blank(5);
        chk("to_seen_cleared", 64'(nframes), 64'd5);
        sb.push_back('{32'h76543210, 8'h00});
        full_scan();
        chk("to_frames", 64'(nframes), 64'd6);
        chk("to_stall_clear", 64'(stall), 64'd0);
`else
        chk("stall_tied_low", 64'(stall), 64'd0);
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
